autoconfig_zii_multi: RTL and testbench

Parametrised Zorro II AutoConfig engine that presents up to NUM_BOARDS logical boards, for example fast RAM, IDE and a future expansion, one after another on a single CFGIN_n/CFGOUT_n chain slot. It generalises the fixed two-board autoconfig used on the SF2000 board. It adds per-board runtime enable, shut-up handling, and a registered nibble read path. It sits between the 68000 bus pins and the per-function decoders, which consume BASE and CONFIGURED_n.

---
 rtl/autoconfig_zii_multi.sv | 170 +++++++++++++++++
 tb/tb_autoconfig_zii_multi.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/autoconfig_zii_multi.sv
// Zorro II AutoConfig engine: presents up to NUM_BOARDS logical boards in turn
// on one CFGIN_n/CFGOUT_n chain slot, with per-board enable and shut-up.
module autoconfig_zii_multi #(
    parameter int                          NUM_BOARDS = 2,
    parameter logic [8*NUM_BOARDS-1:0]     ER_TYPE    = {8'hE5, 8'hD1},
    parameter logic [8*NUM_BOARDS-1:0]     ER_PRODUCT = {8'h02, 8'h01},
    parameter logic [8*NUM_BOARDS-1:0]     ER_FLAGS   = {8'h00, 8'h80},
    parameter logic [15:0]                 MANUF_ID   = 16'h0A1C,
    parameter logic [31:0]                 SERIAL     = 32'h0000_0001
) (
    input  logic                      C7M,
    input  logic                      RESET,
    input  logic                      CFGIN_n,
    input  logic [NUM_BOARDS-1:0]     BOARD_EN,
    input  logic                      AS_n,
    input  logic                      DS_n,
    input  logic                      RW_n,
    input  logic [7:0]                A_HIGH,
    input  logic [5:0]                A_LOW,
    input  logic [3:0]                D_IN,
    output logic [3:0]                D_OUT,
    output logic                      D_OE,
    output logic [8*NUM_BOARDS-1:0]   BASE,
    output logic [NUM_BOARDS-1:0]     CONFIGURED_n,
    output logic [NUM_BOARDS-1:0]     SHUTUP,
    output logic                      CFGOUT_n,
    output logic [1:0]                STATE_DBG
);

    localparam int IDX_W = $clog2(NUM_BOARDS + 1);

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic [3:0]         lo_hold;
    logic               ds_prev;

    logic               hit, rd_hit, wr_edge, wr_base, wr_lo, wr_shut;
    logic [7:0]         sel_type, sel_product, sel_flags;
    logic [3:0]         raw_nib, rd_nib;
    logic               found;
    logic [IDX_W-1:0]   found_idx;

    assign STATE_DBG = state;

    // Bus handshake: a config hit needs the slot enabled, $E8xxxx and AS_n low
    // while a board is being presented; writes commit once on DS_n falling.
    assign hit     = !CFGIN_n && (A_HIGH == 8'hE8) && !AS_n && (state == ST_PRESENT);
    assign rd_hit  = hit && RW_n;
    assign wr_edge = hit && !RW_n && !DS_n && ds_prev;
    assign wr_base = wr_edge && (A_LOW == 6'h24);
    assign wr_lo   = wr_edge && (A_LOW == 6'h25);
    assign wr_shut = wr_edge && (A_LOW == 6'h26);

    always_comb begin
        sel_type    = 8'h00;
        sel_product = 8'h00;
        sel_flags   = 8'h00;
        for (int i = 0; i < NUM_BOARDS; i++) begin
            if (int'(idx) == i) begin
                sel_type    = ER_TYPE[i*8 +: 8];
                sel_product = ER_PRODUCT[i*8 +: 8];
                sel_flags   = ER_FLAGS[i*8 +: 8];
            end
        end
    end

    always_comb begin
        raw_nib = 4'h0;
        case (A_LOW)
            6'd0:  raw_nib = sel_type[7:4];
            6'd1:  raw_nib = sel_type[3:0];
            6'd2:  raw_nib = sel_product[7:4];
            6'd3:  raw_nib = sel_product[3:0];
            6'd4:  raw_nib = sel_flags[7:4];
            6'd5:  raw_nib = sel_flags[3:0];
            6'd8:  raw_nib = MANUF_ID[15:12];
            6'd9:  raw_nib = MANUF_ID[11:8];
            6'd10: raw_nib = MANUF_ID[7:4];
            6'd11: raw_nib = MANUF_ID[3:0];
            6'd12: raw_nib = SERIAL[31:28];
            6'd13: raw_nib = SERIAL[27:24];
            6'd14: raw_nib = SERIAL[23:20];
            6'd15: raw_nib = SERIAL[19:16];
            6'd16: raw_nib = SERIAL[15:12];
            6'd17: raw_nib = SERIAL[11:8];
            6'd18: raw_nib = SERIAL[7:4];
            6'd19: raw_nib = SERIAL[3:0];
            default: raw_nib = 4'h0;
        endcase
        // Only er_Type ($00/$02) is presented true; everything else is inverted.
        rd_nib = (A_LOW <= 6'd1) ? raw_nib : ~raw_nib;
    end

    // Lowest enabled, unconfigured, not-shut-up board at or above idx.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
            if (i >= int'(idx) && BOARD_EN[i] && CONFIGURED_n[i] && !SHUTUP[i]) begin
                found     = 1'b1;
                found_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            ST_SCAN: begin
                if (found) begin
                    state_nx = ST_PRESENT;
                    idx_nx   = found_idx;
                end else begin
                    state_nx = ST_DONE;
                end
            end
            ST_PRESENT: begin
                if (wr_base || wr_shut) begin
                    state_nx = ST_SCAN;
                    idx_nx   = idx + IDX_W'(1);
                end
            end
            default: state_nx = ST_DONE;
        endcase
    end

    always_ff @(posedge C7M) begin
        if (RESET) begin
            state        <= ST_SCAN;
            idx          <= '0;
            lo_hold      <= 4'h0;
            ds_prev      <= 1'b1;
            D_OUT        <= 4'hF;
            D_OE         <= 1'b0;
            BASE         <= '0;
            CONFIGURED_n <= '1;
            SHUTUP       <= '0;
            CFGOUT_n     <= 1'b1;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            ds_prev  <= DS_n;
            D_OE     <= rd_hit;
            D_OUT    <= rd_hit ? rd_nib : 4'hF;
            CFGOUT_n <= (state != ST_DONE) | CFGIN_n;
            if (wr_lo) begin
                lo_hold <= D_IN;
            end
            for (int i = 0; i < NUM_BOARDS; i++) begin
                if (int'(idx) == i) begin
                    if (wr_base) begin
                        BASE[i*8 +: 8]  <= {D_IN, lo_hold};
                        CONFIGURED_n[i] <= 1'b0;
                    end
                    if (wr_shut) begin
                        SHUTUP[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_autoconfig_zii_multi.sv
// Directed bench for autoconfig_zii_multi: two boards, board 0 = type $E5,
// board 1 = type $D1; expected nibbles are hand-derived from the parameters.
module tb_autoconfig_zii_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfgin_n;
    logic [1:0]  board_en;
    logic        as_n, ds_n, rw_n;
    logic [7:0]  a_high;
    logic [5:0]  a_low;
    logic [3:0]  d_in;
    logic [3:0]  d_out;
    logic        d_oe;
    logic [15:0] base;
    logic [1:0]  configured_n;
    logic [1:0]  shutup;
    logic        cfgout_n;
    logic [1:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    autoconfig_zii_multi #(
        .NUM_BOARDS (2),
        .ER_TYPE    ({8'hD1, 8'hE5}),
        .ER_PRODUCT ({8'h02, 8'h01}),
        .ER_FLAGS   ({8'h00, 8'h80}),
        .MANUF_ID   (16'h0A1C),
        .SERIAL     (32'h0000_0001)
    ) dut (
        .C7M          (clk),
        .RESET        (reset),
        .CFGIN_n      (cfgin_n),
        .BOARD_EN     (board_en),
        .AS_n         (as_n),
        .DS_n         (ds_n),
        .RW_n         (rw_n),
        .A_HIGH       (a_high),
        .A_LOW        (a_low),
        .D_IN         (d_in),
        .D_OUT        (d_out),
        .D_OE         (d_oe),
        .BASE         (base),
        .CONFIGURED_n (configured_n),
        .SHUTUP       (shutup),
        .CFGOUT_n     (cfgout_n),
        .STATE_DBG    (state_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        as_n = 1'b1;
        ds_n = 1'b1;
        rw_n = 1'b1;
    endtask

    task automatic do_read(input logic [5:0] a, input logic [3:0] exp, input logic exp_oe,
                           input string tag);
        a_high = 8'hE8;
        a_low  = a;
        rw_n   = 1'b1;
        as_n   = 1'b0;
        ds_n   = 1'b0;
        tick();
        check({tag, "_oe"}, d_oe, exp_oe);
        if (exp_oe) check(tag, d_out, exp);
        bus_idle();
        tick();
        check({tag, "_oe_off"}, d_oe, 1'b0);
    endtask

    task automatic do_write(input logic [5:0] a, input logic [3:0] d, input int hold);
        a_high = 8'hE8;
        a_low  = a;
        d_in   = d;
        rw_n   = 1'b0;
        as_n   = 1'b0;
        ds_n   = 1'b0;
        repeat (hold) tick();
        bus_idle();
        tick();
    endtask

    task automatic do_reset(input logic [1:0] en);
        reset    = 1'b1;
        board_en = en;
        bus_idle();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfgin_n = 1'b0; board_en = 2'b11;
        a_high = 8'h00; a_low = 6'h00; d_in = 4'h0;
        bus_idle();
        tick(); tick();
        check("rst_dout", d_out, 4'hF);
        check("rst_doe", d_oe, 1'b0);
        check("rst_base", base, 16'h0000);
        check("rst_conf", configured_n, 2'b11);
        check("rst_shut", shutup, 2'b00);
        check("rst_cfgout", cfgout_n, 1'b1);
        check("rst_state", state_dbg, 2'd0);

        // Board 0 presented one edge after reset release.
        reset = 1'b0;
        tick();
        check("b0_present", state_dbg, 2'd1);
        do_read(6'd0,  4'hE, 1'b1, "b0_type_hi");
        do_read(6'd1,  4'h5, 1'b1, "b0_type_lo");
        do_read(6'd2,  4'hF, 1'b1, "b0_prod_hi");
        do_read(6'd4,  4'h7, 1'b1, "b0_flags_hi");
        do_read(6'd8,  4'hF, 1'b1, "manuf_0");
        do_read(6'd9,  4'h5, 1'b1, "manuf_1");
        do_read(6'd19, 4'hE, 1'b1, "serial_7");
        do_read(6'd30, 4'hF, 1'b1, "unmapped");
        check("b0_cfgout", cfgout_n, 1'b1);

        do_write(6'h25, 4'h0, 1);
        do_write(6'h24, 4'h2, 1);
        check("b0_base", base, 16'h0020);
        check("b0_conf", configured_n, 2'b10);
        do_read(6'd0, 4'hD, 1'b1, "b1_type_hi");
        do_read(6'd1, 4'h1, 1'b1, "b1_type_lo");

        // Board 1 shut up: chain opens three edges after the commit.
        do_write(6'h26, 4'h0, 1);
        check("shut_cfgout_early", cfgout_n, 1'b1);
        check("shut_bits", shutup, 2'b10);
        check("shut_conf", configured_n, 2'b10);
        tick(); tick();
        check("shut_cfgout", cfgout_n, 1'b0);
        check("shut_done", state_dbg, 2'd2);
        do_read(6'd0, 4'h0, 1'b0, "done_read");

        // Board 0 disabled: board 1 comes first.
        do_reset(2'b10);
        tick();
        do_read(6'd0, 4'hD, 1'b1, "en10_type_hi");
        do_write(6'h25, 4'h3, 1);
        do_write(6'h24, 4'h4, 1);
        tick(); tick();
        check("en10_cfgout", cfgout_n, 1'b0);
        check("en10_base", base, 16'h4300);
        check("en10_conf", configured_n, 2'b01);

        // CFGIN_n high pauses responses; same board returns afterwards.
        do_reset(2'b11);
        cfgin_n = 1'b1;
        tick();
        do_read(6'd0, 4'h0, 1'b0, "cfgin_hi_read");
        check("cfgin_hi_cfgout", cfgout_n, 1'b1);
        cfgin_n = 1'b0;
        do_read(6'd0, 4'hE, 1'b1, "cfgin_lo_read");

        // DS_n held low for four clocks commits exactly once.
        do_write(6'h25, 4'h1, 1);
        do_write(6'h24, 4'h5, 4);
        check("hold_conf", configured_n, 2'b10);
        check("hold_base", base, 16'h0051);
        check("hold_state", state_dbg, 2'd1);
        do_read(6'd0, 4'hD, 1'b1, "hold_b1_type");

        // Reset in the middle of a read.
        a_high = 8'hE8; a_low = 6'd0; rw_n = 1'b1; as_n = 1'b0; ds_n = 1'b0;
        tick();
        check("mid_read_oe", d_oe, 1'b1);
        reset = 1'b1;
        tick();
        check("mid_rst_oe", d_oe, 1'b0);
        check("mid_rst_dout", d_out, 4'hF);
        check("mid_rst_base", base, 16'h0000);
        check("mid_rst_conf", configured_n, 2'b11);
        check("mid_rst_state", state_dbg, 2'd0);
        reset = 1'b0;
        bus_idle();

        // No boards enabled.
        do_reset(2'b00);
        tick();
        check("none_done", state_dbg, 2'd2);
        check("none_cfgout_early", cfgout_n, 1'b1);
        tick();
        check("none_cfgout", cfgout_n, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
